// File: rtl/sha256_msg_ctrl_if.sv
// Signal bundle between the SHA-256 message controller, its word source,
// its compression core and its digest consumer.
interface sha256_msg_ctrl_if;
  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds payload and valid until that edge, and ready never depends
  // combinationally on valid. blk_valid is a one-cycle load strobe, not a handshake.
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] blk_H;
  logic [511:0] blk_M;
  logic         blk_valid;
  logic         blk_done;
  logic [255:0] blk_H_res;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  modport slave (
    input  in_data, in_nbytes, in_last, in_valid, blk_done, blk_H_res, digest_ready,
    output in_ready, blk_H, blk_M, blk_valid, digest, digest_valid
  );

  modport master (
    output in_data, in_nbytes, in_last, in_valid, blk_done, blk_H_res, digest_ready,
    input  in_ready, blk_H, blk_M, blk_valid, digest, digest_valid
  );
endinterface

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message front-end: packs/pads a 32-bit word stream into 512-bit blocks
// and chains sha256_block results. Define SHA256_CTRL_ROUND_COUNT_EN to time blocks with a round counter.
module sha256_msg_ctrl #(
  parameter int SHA256_CTRL_ROUNDS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  sha256_msg_ctrl_if.slave        bus,
  output logic [2:0]              o_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_PAD  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  if (SHA256_CTRL_ROUNDS < 1 || SHA256_CTRL_ROUNDS > 127) begin : g_bad_rounds
    $error("SHA256_CTRL_ROUNDS must fit the 7-bit round counter");
  end

  logic [2:0]   r_state;
  logic [3:0]   r_idx;
  logic [63:0]  r_len;
  logic [31:0]  r_m [16];
  logic [255:0] r_h;
  logic [255:0] r_digest;
  logic [4:0]   r_p;
  logic         r_fin;
  logic         r_lenblk;
  logic         r_pend80;

  logic [31:0]  w_mask;
  logic [31:0]  w_pad80;
  logic [31:0]  w_word;
  logic [4:0]   w_idx_n;
  logic         w_full;
  logic         w_done;

  always_comb begin
    w_mask  = 32'hffffffff;
    w_pad80 = 32'h00000000;
    case (bus.in_nbytes)
      3'd0: begin w_mask = 32'h00000000; w_pad80 = 32'h80000000; end
      3'd1: begin w_mask = 32'hff000000; w_pad80 = 32'h00800000; end
      3'd2: begin w_mask = 32'hffff0000; w_pad80 = 32'h00008000; end
      3'd3: begin w_mask = 32'hffffff00; w_pad80 = 32'h00000080; end
      default: begin w_mask = 32'hffffffff; w_pad80 = 32'h00000000; end
    endcase
  end

  assign w_word  = bus.in_data & w_mask;
  assign w_full  = bus.in_nbytes[2];
  assign w_idx_n = {1'b0, r_idx} + 5'd1;

`ifdef SHA256_CTRL_ROUND_COUNT_EN
  localparam logic [6:0] LP_ROUNDS = 7'(SHA256_CTRL_ROUNDS);
  logic [6:0] r_cnt;

  // Counter reads 0 in the first WAIT cycle, so completion lands ROUNDS cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (r_state == S_SEND)  r_cnt <= '0;
    else if (r_state == S_WAIT)  r_cnt <= r_cnt + 7'd1;
  end

  assign w_done = (r_state == S_WAIT) && (r_cnt == LP_ROUNDS);
`else
  assign w_done = (r_state == S_WAIT) && bus.blk_done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_len    <= '0;
      for (int i = 0; i < 16; i++) r_m[i] <= '0;
      r_h      <= H0;
      r_digest <= '0;
      r_p      <= '0;
      r_fin    <= 1'b0;
      r_lenblk <= 1'b0;
      r_pend80 <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_h      <= H0;
          r_len    <= '0;
          r_idx    <= '0;
          for (int i = 0; i < 16; i++) r_m[i] <= '0;
          r_fin    <= 1'b0;
          r_lenblk <= 1'b0;
          r_pend80 <= 1'b0;
          r_state  <= S_FILL;
        end
        S_FILL: begin
          if (bus.in_valid) begin
            r_len <= r_len + {58'd0, bus.in_nbytes, 3'd0};
            if (bus.in_last) begin
              if (!w_full) begin
                r_m[r_idx] <= w_word | w_pad80;
                r_p        <= w_idx_n;
              end else begin
                r_m[r_idx] <= w_word;
                // A full final word in slot 15 pushes the 0x80 marker into the next block.
                if (r_idx != 4'd15) begin
                  r_m[r_idx + 4'd1] <= 32'h80000000;
                  r_p               <= w_idx_n + 5'd1;
                end else begin
                  r_pend80 <= 1'b1;
                  r_p      <= 5'd16;
                end
              end
              r_state <= S_PAD;
            end else begin
              r_m[r_idx] <= w_word;
              if (r_idx == 4'd15) begin
                r_fin   <= 1'b0;
                r_state <= S_SEND;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end
          end
        end
        S_PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) >= r_p) r_m[i] <= '0;
          end
          if (r_p <= 5'd14) begin
            r_m[14] <= r_len[63:32];
            r_m[15] <= r_len[31:0];
            r_fin   <= 1'b1;
          end else begin
            r_fin    <= 1'b0;
            r_lenblk <= 1'b1;
          end
          r_state <= S_SEND;
        end
        S_SEND: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_done) begin
            r_h <= bus.blk_H_res;
            if (r_fin) begin
              r_digest <= bus.blk_H_res;
              r_state  <= S_DONE;
            end else if (r_lenblk || r_pend80) begin
              for (int i = 0; i < 16; i++) r_m[i] <= '0;
              r_m[0]   <= r_pend80 ? 32'h80000000 : 32'h00000000;
              r_m[14]  <= r_len[63:32];
              r_m[15]  <= r_len[31:0];
              r_fin    <= 1'b1;
              r_lenblk <= 1'b0;
              r_pend80 <= 1'b0;
              r_state  <= S_SEND;
            end else begin
              for (int i = 0; i < 16; i++) r_m[i] <= '0;
              r_idx   <= '0;
              r_state <= S_FILL;
            end
          end
        end
        S_DONE: begin
          if (bus.digest_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.blk_M = '0;
    for (int i = 0; i < 16; i++) bus.blk_M[511 - 32*i -: 32] = r_m[i];
  end

  assign bus.in_ready     = (r_state == S_FILL);
  assign bus.blk_valid    = (r_state == S_SEND);
  assign bus.digest_valid = (r_state == S_DONE);
  assign bus.blk_H        = r_h;
  assign bus.digest       = r_digest;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: directed messages, a behavioural compression core,
// and queue-based monitors for blocks and digests.
module tb_sha256_msg_ctrl;

  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  sha256_msg_ctrl_if bus();

  sha256_msg_ctrl #(.SHA256_CTRL_ROUNDS(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [511:0] exp_q[$];
  logic [255:0] exp_dig_q[$];
  logic [7:0]   msg_q[$];
  int           lat_min = 1;
  int           lat_max = 6;

  task automatic tally(input string name, input bit ok, input string got, input string want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %s expected %s", name, got, want);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    tally(name, act === exp, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    tally(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
    tally(name, act === exp, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tally(name, act == exp, $sformatf("%0d", act), $sformatf("%0d", exp));
  endtask

  // ---------------- reference compression core ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Core model: captures each load, drives blk_done after a random delay,
  // toggles junk on blk_done while no block is in flight.
  initial begin : blk_model
    logic [255:0] cap_h;
    logic [511:0] cap_m;
    logic [255:0] res;
    int           lat;
    bit           stable;
    bit           aborted;
    bus.blk_done  = 1'b0;
    bus.blk_H_res = {8{$urandom()}};
    forever begin
      @(posedge clk); #1;
      bus.blk_done = 1'($urandom_range(0, 1));
      while (rst && bus.blk_valid) begin
        bus.blk_done = 1'b0;
        cap_h   = bus.blk_H;
        cap_m   = bus.blk_M;
        res     = sha_compress(cap_h, cap_m);
        lat     = $urandom_range(lat_min, lat_max);
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < lat && !aborted; i++) begin
          @(posedge clk); #1;
          if (!rst) aborted = 1'b1;
          else if (bus.blk_H !== cap_h || bus.blk_M !== cap_m) stable = 1'b0;
        end
        if (!aborted) begin
          bus.blk_done  = 1'b1;
          bus.blk_H_res = res;
          @(posedge clk); #1;
          bus.blk_done  = 1'b0;
          bus.blk_H_res = {8{$urandom()}};
          chk_bit("blk_stable_in_wait", stable, 1'b1);
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : blk_mon
    forever begin
      @(posedge clk); #1;
      if (rst && bus.blk_valid) begin
        if (exp_q.size() == 0) tally("blk_unexpected", 1'b0, "block", "none");
        else chk512("blk_M", bus.blk_M, exp_q.pop_front());
        @(posedge clk); #1;
        if (rst) chk_bit("blk_valid_pulse", bus.blk_valid, 1'b0);
      end
    end
  end

  initial begin : dig_mon
    logic [255:0] first;
    bit           stable;
    int           cyc;
    forever begin
      @(posedge clk); #1;
      if (rst && bus.digest_valid) begin
        if (exp_dig_q.size() == 0) tally("digest_unexpected", 1'b0, "digest", "none");
        else chk256("digest", bus.digest, exp_dig_q.pop_front());
        first  = bus.digest;
        stable = 1'b1;
        cyc    = 0;
        while (rst && bus.digest_valid && cyc < 500) begin
          if (bus.digest !== first) stable = 1'b0;
          @(posedge clk); #1;
          cyc++;
        end
        chk_bit("digest_stable", stable, 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values(input string tag);
    chk_bit({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk_bit({tag, "_blk_valid"}, bus.blk_valid, 1'b0);
    chk_bit({tag, "_digest_valid"}, bus.digest_valid, 1'b0);
    chk512({tag, "_blk_M"}, bus.blk_M, 512'd0);
    chk256({tag, "_digest"}, bus.digest, 256'd0);
    chk256({tag, "_blk_H"}, bus.blk_H, H0);
    chk_int({tag, "_state"}, int'(dbg_state), 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input bit last,
                           input int gap_max, input int pos);
    int waited;
    waited = 0;
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.in_data   = d;
    bus.in_nbytes = nb;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      tally("in_ready_timeout", 1'b0, "0", "1");
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = $urandom();
    bus.in_nbytes = 3'($urandom_range(0, 4));
    bus.in_last   = 1'($urandom_range(0, 1));
    chk_bit("in_ready_after_beat", bus.in_ready, (last || pos == 15) ? 1'b0 : 1'b1);
  endtask

  task automatic send_msg(input int gap_max);
    int n;
    int nbeats;
    int nb;
    logic [31:0] d;
    n      = msg_q.size();
    nbeats = (n == 0) ? 1 : (n + 3) / 4;
    for (int k = 0; k < nbeats; k++) begin
      d  = 32'ha5a5a5a5;
      nb = n - 4*k;
      if (nb > 4) nb = 4;
      for (int j = 0; j < nb; j++) d[31 - 8*j -: 8] = msg_q[4*k + j];
      send_beat(d, 3'(nb), k == nbeats - 1, gap_max, k % 16);
    end
  endtask

  task automatic run_msg(input int gap_max, input int hold);
    int w;
    w = 0;
    bus.digest_ready = (hold == 0);
    send_msg(gap_max);
    while (!bus.digest_valid && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.digest_valid) begin
      tally("digest_timeout", 1'b0, "0", "1");
    end else begin
      repeat (hold) @(negedge clk);
      chk_bit("digest_held", bus.digest_valid, 1'b1);
      bus.digest_ready = 1'b1;
      @(negedge clk);
      chk_bit("digest_valid_drop", bus.digest_valid, 1'b0);
    end
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endtask

  task automatic load_seq(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [511:0] b1;
    logic [511:0] b2;
    logic [511:0] blk56;
    int           w;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_nbytes    = '0;
    bus.in_last      = 1'b0;
    bus.digest_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_bit("fill_after_idle", bus.in_ready, 1'b1);

    // "abc": one block, junk in the unused byte lane
    b1 = '0;
    b1[511:480] = 32'h61626380;
    b1[31:0]    = 32'h00000018;
    exp_q.push_back(b1);
    exp_dig_q.push_back(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    load_str("abc");
    run_msg(0, 0);

    // empty message
    exp_q.push_back({32'h80000000, 480'd0});
    exp_dig_q.push_back(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    msg_q.delete();
    run_msg(0, 0);

    // 56 bytes: marker fits at word 14, length needs an extra block
    blk56 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
             32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
             32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    exp_q.push_back(blk56);
    exp_q.push_back({480'd0, 32'h000001c0});
    exp_dig_q.push_back(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(0, 0);

    // 64 bytes: marker deferred into the trailer block
    for (int i = 0; i < 16; i++) b1[511 - 32*i -: 32] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    b2 = {32'h80000000, 448'd0, 32'h00000200};
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_dig_q.push_back(sha_compress(sha_compress(H0, b1), b2));
    load_seq(64);
    run_msg(0, 0);

    // 63 bytes: partial final word in slot 15, length-only trailer
    b1[31:0] = 32'h3c3d3e80;
    b2 = {480'd0, 32'h000001f8};
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_dig_q.push_back(sha_compress(sha_compress(H0, b1), b2));
    load_seq(63);
    run_msg(0, 0);

    // random source gaps, consumer stalls 20 cycles
    exp_q.push_back(blk56);
    exp_q.push_back({480'd0, 32'h000001c0});
    exp_dig_q.push_back(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
    load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    run_msg(3, 20);

    // reset pulse in the middle of WAIT, then a clean "abc"
    lat_min = 10;
    lat_max = 12;
    b1 = '0;
    b1[511:480] = 32'h61626380;
    b1[31:0]    = 32'h00000018;
    exp_q.push_back(b1);
    load_str("abc");
    send_msg(0);
    w = 0;
    while (!bus.blk_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk_bit("blk_valid_before_reset", bus.blk_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("mid_wait_reset");
    @(negedge clk);
    rst = 1'b1;
    lat_min = 1;
    lat_max = 6;
    @(negedge clk);
    chk_bit("fill_after_reset", bus.in_ready, 1'b1);
    exp_q.push_back(b1);
    exp_dig_q.push_back(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    run_msg(2, 3);

    repeat (5) @(negedge clk);
    chk_int("blk_queue_empty", exp_q.size(), 0);
    chk_int("digest_queue_empty", exp_dig_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
